imem_boot: RTL and testbench

IMEM_BOOT -- requirements
Module: imem_boot

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_ram.sv | 44 ++++
 rtl/imem_boot.sv | 178 +++++++++++++++++
 tb/tb_imem_boot.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
// Optional parity protection is enabled with `define IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  localparam int NOP_INS = 0;

endpackage

// File: rtl/imem_ram.sv
// Single-write-port array with a registered read port that holds between reads.
// Built DW bits wide; the top adds one bit per word when IMEM_PARITY_EN is defined.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic          rclr_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the array has no reset branch; contents survive reset, and only the read register is cleared.
  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdata_q <= DW'(NOP_INS);
    end else if (rclr_i) begin
      rdata_q <= DW'(NOP_INS);
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_boot.sv
// Instruction memory filled by a streaming boot loader, then read by fetches.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_boot
  import imem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int PC_W  = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ld_start,
  input  logic [$clog2(DEPTH):0] ld_count,
  input  logic                   ld_valid,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   ld_ready,
  output logic                   ld_done,
  input  logic                   fetch_req,
  input  logic [PC_W-1:0]        fetch_pc,
  output logic                   fetch_valid,
  output logic [WIDTH-1:0]       fetch_ins,
  output logic                   fetch_fault,
  output logic                   busy,
  output logic                   parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef IMEM_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  imem_state_e   state_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] last_q;
  logic [AW-1:0] last_d;
  logic          ld_ready_q;
  logic          ld_done_q;
  logic          busy_q;
  logic          fetch_valid_q;
  logic          addr_fault_q;

  logic          wr_en;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;
  logic [PC_W-1:0] pc_idx;
  logic          pc_fault;
  logic          fetch_go;

  // Index of the final word of the session; oversized counts stop at the array end.
  always_comb begin
    last_d = AW'(ld_count - 1'b1);
    if (ld_count > CW'(DEPTH)) begin
      last_d = AW'(DEPTH - 1);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      last_q     <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (ld_start) begin
            wptr_q <= '0;
            last_q <= last_d;
            if (ld_count == '0) begin
              state_q    <= RUN;
              ld_done_q  <= 1'b1;
              ld_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= LOAD;
              ld_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            wptr_q <= wptr_q + 1'b1;
            if (wptr_q == last_q) begin
              state_q    <= RUN;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          ld_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign wr_en = RST && (state_q == LOAD) && ld_valid;
`ifdef IMEM_PARITY_EN
  assign wr_word = {^ld_data, ld_data};
`else
  assign wr_word = ld_data;
`endif

  assign pc_idx   = fetch_pc >> 2;
  assign pc_fault = (fetch_pc[1:0] != 2'b00) || (pc_idx >= PC_W'(DEPTH));
  assign fetch_go = RST && (state_q == RUN) && fetch_req;

  // A faulting fetch clears the read register so the NOP is what gets held afterwards.
  imem_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .re_i    (fetch_go && !pc_fault),
    .rclr_i  (fetch_go && pc_fault),
    .raddr_i (fetch_pc[AW+1:2]),
    .rdata_o (rd_word)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      if (fetch_go) begin
        addr_fault_q <= pc_fault;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_bad_raw;
  logic par_bad;
  logic parity_err_q;

  assign par_bad_raw = ^rd_word;
  assign par_bad     = fetch_valid_q && par_bad_raw;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      parity_err_q <= 1'b0;
    end else if (par_bad) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err  = parity_err_q || par_bad;
  assign fetch_ins   = par_bad_raw ? WIDTH'(NOP_INS) : rd_word[WIDTH-1:0];
  assign fetch_fault = fetch_valid_q && (addr_fault_q || par_bad_raw);
`else
  assign parity_err  = 1'b0;
  assign fetch_ins   = rd_word;
  assign fetch_fault = fetch_valid_q && addr_fault_q;
`endif

  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign busy        = busy_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_imem_boot.sv
// Scoreboard bench for imem_boot: directed loads and fetches, fetch results checked by a monitor.
// The parity scenario runs only when IMEM_PARITY_EN is defined.
module tb_imem_boot;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ld_start = 1'b0;
  logic [CNT_W-1:0] ld_count = '0;
  logic             ld_valid = 1'b0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             ld_ready;
  logic             ld_done;
  logic             fetch_req = 1'b0;
  logic [PC_W-1:0]  fetch_pc = '0;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_ins;
  logic             fetch_fault;
  logic             busy;
  logic             parity_err;

  imem_boot #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ld_start    (ld_start),
    .ld_count    (ld_count),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_ins   (fetch_ins),
    .fetch_fault (fetch_fault),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] ins;
    logic             fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic tb_run = 1'b0;
  logic exp_v  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A result is due in the cycle after any request sampled while the DUT should be in RUN.
  always @(posedge CLK) exp_v <= fetch_req && tb_run && RST;

  always @(negedge CLK) begin
    exp_t e;
    if (exp_v || fetch_valid) begin
      n_cmp++;
      if (fetch_valid !== exp_v) begin
        n_fail++;
        $display("FAIL fetch_valid_timing: got %b expected %b", fetch_valid, exp_v);
      end
      if (exp_v && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (fetch_valid === 1'b1) begin
          n_cmp++;
          if (fetch_ins !== e.ins) begin
            n_fail++;
            $display("FAIL fetch_ins: got 0x%0h expected 0x%0h", fetch_ins, e.ins);
          end
          n_cmp++;
          if (fetch_fault !== e.fault) begin
            n_fail++;
            $display("FAIL fetch_fault: got %b expected %b", fetch_fault, e.fault);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load(input int cnt);
    tb_run   = 1'b0;
    ld_start = 1'b1;
    ld_count = CNT_W'(cnt);
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    ld_valid = 1'b1;
    ld_data  = w;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [PC_W-1:0] pc, input logic [WIDTH-1:0] ins, input logic fault);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    if (tb_run) sb_q.push_back({ins, fault});
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check("rst_fetch_ins", fetch_ins, 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    RST = 1'b1;
    tick();

    // Load of four words with a two-cycle valid gap and fetches ignored during LOAD
    start_load(4);
    check("load_ready", 32'(ld_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    send_word(32'h11);
    send_word(32'h22);
    fetch_req = 1'b1;
    fetch_pc  = 32'h8;
    tick();
    check("load_fetch_ignored", 32'(fetch_valid), 32'd0);
    tick();
    fetch_req = 1'b0;
    check("gap_no_done", 32'(ld_done), 32'd0);
    check("gap_still_ready", 32'(ld_ready), 32'd1);
    send_word(32'h33);
    send_word(32'h44);
    check("load4_done", 32'(ld_done), 32'd1);
    check("load4_busy", 32'(busy), 32'd0);
    check("load4_ready_drop", 32'(ld_ready), 32'd0);
    tb_run = 1'b1;

    // Fetches back to back, including misaligned and out-of-range addresses
    fetch(32'h8, 32'h33, 1'b0);
    check("done_one_cycle", 32'(ld_done), 32'd0);
    fetch(32'h0, 32'h11, 1'b0);
    fetch(32'h4, 32'h22, 1'b0);
    fetch(32'hC, 32'h44, 1'b0);
    fetch(32'h6, 32'h0, 1'b1);
    fetch(32'(4 * DEPTH), 32'h0, 1'b1);
    tick();
    check("hold_after_fault_ins", fetch_ins, 32'h0);
    check("idle_fault_low", 32'(fetch_fault), 32'd0);
    fetch(32'h4, 32'h22, 1'b0);
    tick();
    tick();
    check("hold_ins", fetch_ins, 32'h22);

    // Restart from RUN, abort with reset after two words, then reload two words
    start_load(4);
    check("restart_busy", 32'(busy), 32'd1);
    send_word(32'hA1);
    send_word(32'hA2);
    RST = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_ready", 32'(ld_ready), 32'd0);
    check("abort_no_done", 32'(ld_done), 32'd0);
    RST = 1'b1;
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    tick();
    fetch_req = 1'b0;
    check("idle_fetch_ignored", 32'(fetch_valid), 32'd0);
    check("idle_no_done", 32'(ld_done), 32'd0);
    start_load(2);
    send_word(32'hB1);
    send_word(32'hB2);
    check("reload_done", 32'(ld_done), 32'd1);
    tb_run = 1'b1;
    fetch(32'h0, 32'hB1, 1'b0);
    fetch(32'h4, 32'hB2, 1'b0);
    fetch(32'h8, 32'h33, 1'b0);
    fetch(32'hC, 32'h44, 1'b0);

    // Zero-length session and an oversized count clipped at DEPTH
    start_load(0);
    check("zero_done", 32'(ld_done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_ready", 32'(ld_ready), 32'd0);
    tick();
    check("zero_done_pulse", 32'(ld_done), 32'd0);
    start_load(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("over_no_early_done", 32'(ld_done), 32'd0);
      send_word(32'h100 + 32'(i));
    end
    check("over_done", 32'(ld_done), 32'd1);
    check("over_ready", 32'(ld_ready), 32'd0);
    check("over_busy", 32'(busy), 32'd0);
    send_word(32'hDEAD);
    tb_run = 1'b1;
    fetch(32'h0, 32'h100, 1'b0);
    fetch(32'(4 * (DEPTH - 1)), 32'h10F, 1'b0);

`ifdef IMEM_PARITY_EN
    // Corrupt one stored bit and confirm the sticky error flag
    dut.u_ram.mem_q[1][0] = ~dut.u_ram.mem_q[1][0];
    fetch(32'h4, 32'h0, 1'b1);
    check("parity_err_set", 32'(parity_err), 32'd1);
    fetch(32'h0, 32'h100, 1'b0);
    tick();
    check("parity_err_sticky", 32'(parity_err), 32'd1);
    RST = 1'b0;
    tb_run = 1'b0;
    tick();
    check("parity_err_reset", 32'(parity_err), 32'd0);
    RST = 1'b1;
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
